// File: rtl/dpram_pkg.sv
// Shared types and constants for the single-clock simple dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam bit RDW_OLD = 1'b0;
    localparam bit RDW_NEW = 1'b1;

    // Address width needed to cover n words.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 1) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram_core.sv
// Bare storage array: one synchronous write port, one registered read port, no reset.
module dpram_core #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dpram_sclk_param.sv
// Single-clock simple dual-port RAM with post-reset clear sweep, selectable
// read latency, read-during-write policy and a read-valid strobe.
module dpram_sclk_param #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned RD_LAT     = 1,
    parameter bit          RDW_NEW    = 1'b0,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              init_busy
);
    import dpram_pkg::*;

    localparam int unsigned       DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_e            state;
    logic [ADDR_W-1:0] cnt;
    logic              sweep;
    logic              wr_go;
    logic              rd_go;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q;
    logic              v1;
    logic              byp1;
    logic [DATA_W-1:0] wd1;
    logic [DATA_W-1:0] s1_data;

    // Nothing reaches the array or the read pipe on a reset edge.
    assign sweep     = (state == ST_INIT) && !reset;
    assign wr_go     = (state == ST_RUN) && we && !reset;
    assign rd_go     = (state == ST_RUN) && re && !reset;
    assign mem_we    = sweep || wr_go;
    assign mem_waddr = sweep ? cnt : waddr;
    assign mem_wdata = sweep ? '0 : wdata;

    dpram_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_core (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .re   (rd_go),
        .raddr(raddr),
        .rdata(mem_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLR_ON_RST ? ST_INIT : ST_RUN;
            init_busy <= CLR_ON_RST;
            cnt       <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == LAST) begin
                state     <= ST_RUN;
                init_busy <= 1'b0;
            end
        end
    end

    // Stage 1: valid bit plus bypass decision, fixed at issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1   <= 1'b0;
            byp1 <= 1'b0;
        end else begin
            v1   <= rd_go;
            byp1 <= rd_go && RDW_NEW && wr_go && (waddr == raddr);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_go) begin
            wd1 <= wdata;
        end
    end

    assign s1_data = byp1 ? wd1 : mem_q;

    generate
        if (RD_LAT == 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid <= 1'b0;
                    rdata  <= '0;
                end else begin
                    rvalid <= v1;
                    rdata  <= v1 ? s1_data : '0;
                end
            end
        end else begin : g_lat1
            assign rvalid = v1;
            assign rdata  = v1 ? s1_data : '0;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_sclk_param.sv
// Directed bench: three builds (A: lat1/old/clear, B: lat2/new/clear, C: lat1/new/no-clear) on shared inputs.
module tb_dpram_sclk_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [2:0] waddr;
    logic [9:0] wdata;
    logic       re;
    logic [2:0] raddr;

    logic [9:0] rdata_a, rdata_b, rdata_c;
    logic       rvalid_a, rvalid_b, rvalid_c;
    logic       busy_a, busy_b, busy_c;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dpram_sclk_param #(.DATA_W(10), .ADDR_W(3), .RD_LAT(1), .RDW_NEW(1'b0), .CLR_ON_RST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
        .rdata(rdata_a), .rvalid(rvalid_a), .init_busy(busy_a)
    );

    dpram_sclk_param #(.DATA_W(10), .ADDR_W(3), .RD_LAT(2), .RDW_NEW(1'b1), .CLR_ON_RST(1'b1)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
        .rdata(rdata_b), .rvalid(rvalid_b), .init_busy(busy_b)
    );

    dpram_sclk_param #(.DATA_W(10), .ADDR_W(3), .RD_LAT(1), .RDW_NEW(1'b1), .CLR_ON_RST(1'b0)) dut_c (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
        .rdata(rdata_c), .rvalid(rvalid_c), .init_busy(busy_c)
    );

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [9:0] wd,
                         input logic r, input logic [2:0] ra);
        we    = w;
        waddr = wa;
        wdata = wd;
        re    = r;
        raddr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, 10'h000, 1'b0, 3'd0);
        #2;
        tick();
        reset = 1'b0;
        chk("rst_busy_a", 10'(busy_a), 10'd1);
        chk("rst_rvalid_a", 10'(rvalid_a), 10'd0);
        chk("rst_rdata_a", rdata_a, 10'h000);
        chk("rst_rvalid_b", 10'(rvalid_b), 10'd0);
        chk("rst_busy_c", 10'(busy_c), 10'd0);
        chk("rst_rvalid_c", 10'(rvalid_c), 10'd0);

        // Sweep window with re/we held high: A and B must ignore them.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd1, 10'h3FF, 1'b1, 3'd1);
            tick();
            chk($sformatf("init_busy_a_%0d", i), 10'(busy_a), (i < 7) ? 10'd1 : 10'd0);
            chk($sformatf("init_rvalid_a_%0d", i), 10'(rvalid_a), 10'd0);
            chk($sformatf("init_busy_b_%0d", i), 10'(busy_b), (i < 7) ? 10'd1 : 10'd0);
            chk($sformatf("init_rvalid_b_%0d", i), 10'(rvalid_b), 10'd0);
            chk($sformatf("init_rvalid_c_%0d", i), 10'(rvalid_c), 10'd1);
        end

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 10'h000, 1'b1, 3'(i));
            tick();
            chk($sformatf("clr_rvalid_a_%0d", i), 10'(rvalid_a), 10'd1);
            chk($sformatf("clr_rdata_a_%0d", i), rdata_a, 10'h000);
            chk($sformatf("clr_rdata_b_%0d", i), rdata_b, 10'h000);
        end

        drive(1'b1, 3'd2, 10'h155, 1'b0, 3'd0);
        tick();
        drive(1'b1, 3'd5, 10'h2AA, 1'b0, 3'd0);
        tick();
        chk("wr_rvalid_a", 10'(rvalid_a), 10'd0);
        chk("wr_rdata_a", rdata_a, 10'h000);
        chk("wr_rvalid_b", 10'(rvalid_b), 10'd0);

        drive(1'b0, 3'd0, 10'h000, 1'b1, 3'd5);
        tick();
        chk("rd5_rdata_a", rdata_a, 10'h2AA);
        chk("rd5_rvalid_a", 10'(rvalid_a), 10'd1);
        chk("rd5_rvalid_b_early", 10'(rvalid_b), 10'd0);
        drive(1'b0, 3'd0, 10'h000, 1'b1, 3'd2);
        tick();
        chk("rd2_rdata_a", rdata_a, 10'h155);
        chk("rd5_rvalid_b", 10'(rvalid_b), 10'd1);
        chk("rd5_rdata_b", rdata_b, 10'h2AA);
        drive(1'b0, 3'd0, 10'h000, 1'b0, 3'd0);
        tick();
        chk("idle_rvalid_a", 10'(rvalid_a), 10'd0);
        chk("idle_rdata_a", rdata_a, 10'h000);
        chk("rd2_rdata_b", rdata_b, 10'h155);
        tick();
        chk("idle_rvalid_b", 10'(rvalid_b), 10'd0);
        chk("idle_rdata_b", rdata_b, 10'h000);

        // Read-during-write on address 3.
        drive(1'b1, 3'd3, 10'h011, 1'b0, 3'd0);
        tick();
        drive(1'b1, 3'd3, 10'h3FF, 1'b1, 3'd3);
        tick();
        chk("rdw_old_a", rdata_a, 10'h011);
        chk("rdw_new_c", rdata_c, 10'h3FF);
        drive(1'b1, 3'd4, 10'h123, 1'b1, 3'd3);
        tick();
        chk("rdw_follow_a", rdata_a, 10'h3FF);
        chk("rdw_new_b", rdata_b, 10'h3FF);
        drive(1'b1, 3'd3, 10'h0F0, 1'b0, 3'd0);
        tick();
        chk("rdw_idle_rvalid_a", 10'(rvalid_a), 10'd0);
        chk("stage2_hold_b", rdata_b, 10'h3FF);
        drive(1'b0, 3'd0, 10'h000, 1'b1, 3'd3);
        tick();
        chk("rd3_after_wr_a", rdata_a, 10'h0F0);
        drive(1'b0, 3'd0, 10'h000, 1'b1, 3'd4);
        tick();
        chk("rd4_indep_a", rdata_a, 10'h123);
        chk("rd3_after_wr_b", rdata_b, 10'h0F0);
        drive(1'b0, 3'd0, 10'h000, 1'b0, 3'd0);
        tick();
        chk("rd4_indep_b", rdata_b, 10'h123);

        // Reset in the middle of a read stream.
        drive(1'b1, 3'd7, 10'h0AB, 1'b1, 3'd2);
        tick();
        chk("stream_a", rdata_a, 10'h155);
        drive(1'b0, 3'd0, 10'h000, 1'b1, 3'd2);
        tick();
        chk("stream_a2", rdata_a, 10'h155);
        chk("stream_b", rdata_b, 10'h155);
        reset = 1'b1;
        drive(1'b1, 3'd7, 10'h1FF, 1'b1, 3'd2);
        tick();
        reset = 1'b0;
        chk("mrst_rvalid_a", 10'(rvalid_a), 10'd0);
        chk("mrst_rdata_a", rdata_a, 10'h000);
        chk("mrst_busy_a", 10'(busy_a), 10'd1);
        chk("mrst_rvalid_b", 10'(rvalid_b), 10'd0);
        chk("mrst_rdata_b", rdata_b, 10'h000);
        chk("mrst_busy_b", 10'(busy_b), 10'd1);
        chk("mrst_rvalid_c", 10'(rvalid_c), 10'd0);
        chk("mrst_busy_c", 10'(busy_c), 10'd0);

        drive(1'b0, 3'd0, 10'h000, 1'b1, 3'd7);
        tick();
        chk("norclr_rvalid_c", 10'(rvalid_c), 10'd1);
        chk("norclr_rdata_c", rdata_c, 10'h0AB);
        chk("resweep_rvalid_a", 10'(rvalid_a), 10'd0);
        chk("resweep_busy_a", 10'(busy_a), 10'd1);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 3'd0, 10'h000, 1'b0, 3'd0);
            tick();
            chk($sformatf("resweep_busy_a_%0d", i), 10'(busy_a), (i < 7) ? 10'd1 : 10'd0);
        end

        drive(1'b0, 3'd0, 10'h000, 1'b1, 3'd2);
        tick();
        chk("cleared2_rvalid_a", 10'(rvalid_a), 10'd1);
        chk("cleared2_rdata_a", rdata_a, 10'h000);
        chk("kept2_rdata_c", rdata_c, 10'h155);
        drive(1'b0, 3'd0, 10'h000, 1'b1, 3'd7);
        tick();
        chk("cleared7_rdata_a", rdata_a, 10'h000);
        chk("dropwr7_rdata_c", rdata_c, 10'h0AB);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
